usb_rx_ctrl: RTL and testbench
==============================

# usb_rx_ctrl

Receive control unit for the USB full-speed receiver. It sequences the NRZI decode / shift-register datapath for one packet at a time. It detects packet start, validates the SYNC byte and removes stuffed bits. It counts bits into bytes, issues FIFO write strobes and checks EOP alignment. It sits between the edge/EOP detectors plus NRZI decoder and the RX FIFO.

## Interface
- SYNC_BYTE, 8'h80: required value of the first received byte (LSB-first assembled)
- MAX_BYTES, 64: maximum data bytes per packet; a further completed byte is an overflow error
- clk  in  1  system clock
- n_rst  in  1  reset, asynchronous, active-low
- d_edge  in  1  single-cycle pulse: transition detected on d_plus
- eop  in  1  level: SE0 present on the bus
- shift_enable  in  1  single-cycle bit-sample strobe from the timing block
- d_orig  in  1  decoded (NRZI-removed) bit, valid when shift_enable=1
- rcv_data  in  8  current shift-register contents
- shift_gate  out  1  combinational: shift the register this cycle
- rcving  out  1  packet reception in progress
- w_enable  out  1  one-cycle FIFO write strobe for rcv_data
- r_error  out  1  packet error flag, held until the next packet start
- pkt_done  out  1  one-cycle pulse on clean packet end

## Operation
- States: IDLE, SYNC, CHK_SYNC, DATA, STORE, EOP_WAIT, ERR_EOP, ERR_IDLE.
- Counters: bit_cnt (0–8), ones_cnt (0–6), byte_cnt (0..MAX_BYTES, width $clog2(MAX_BYTES+1)).
- Valid sample: shift_enable=1 and eop=0, in state SYNC or DATA.
- Stuff handling on a valid sample:
  - ones_cnt==6: the bit is stuffed. d_orig=0 gives ones_cnt←0, no shift, bit_cnt unchanged. d_orig=1 is a stuff error → ERR_EOP.
  - Otherwise: shift_gate=1, bit_cnt++, ones_cnt←d_orig ? ones_cnt+1 : 0.
- IDLE / ERR_IDLE: on d_edge → SYNC. Clear bit_cnt, ones_cnt, byte_cnt and r_error.
- SYNC: on bit_cnt reaching 8 → CHK_SYNC. eop=1 with shift_enable → ERR_EOP.
- CHK_SYNC (one cycle):
  - rcv_data==SYNC_BYTE → DATA, bit_cnt←0.
  - Otherwise → ERR_EOP.
  - ones_cnt carries over, so SYNC's trailing 1 counts toward stuffing.
- DATA:
  - bit_cnt reaching 8 → STORE.
  - eop=1 with shift_enable: bit_cnt==0 → EOP_WAIT; bit_cnt≠0 → ERR_EOP.
- STORE (one cycle):
  - byte_cnt==MAX_BYTES → ERR_EOP, no write.
  - Otherwise w_enable=1, byte_cnt++, bit_cnt←0 → DATA.
- EOP_WAIT: eop=0 → IDLE with pkt_done=1 for that cycle.
- ERR_EOP: r_error=1; wait for eop=1 then eop=0 → ERR_IDLE. Intervening d_edge is ignored.
- ERR_IDLE: r_error stays 1; rcving=0.
- rcving=1 in SYNC, CHK_SYNC, DATA, STORE, EOP_WAIT. It is 0 elsewhere.

## Timing
- Reset values:
  - state=IDLE
  - rcving=0, w_enable=0, r_error=0, pkt_done=0
  - all counters 0
- Outputs are registered state decodes, except shift_gate, which is combinational and asserted in the same cycle as the valid sample.
- rcv_data is sampled in CHK_SYNC/STORE, the cycle after the 8th shift. The shift register updates on the shift_gate cycle.
- w_enable is asserted 1 cycle after the 8th data bit's shift_gate. shift_enable is never closer than 4 cycles apart, so STORE always completes before the next sample.
- d_edge has priority only in IDLE / ERR_IDLE; it is ignored in all other states.
- eop and shift_enable in the same cycle: EOP rules apply, no shift.
- Stuffed bit coincident with bit_cnt==7: the bit is dropped and the byte completes on the next valid sample.
- Reset mid-packet: immediate return to IDLE, outputs to reset values, no w_enable.

## Structure
- Package usb_rx_pkg holds:
  - state enum rx_state_t
  - constant STUFF_LIMIT=6
  - constant BITS_PER_BYTE=8
- Single module, no sub-modules. The three counters and the FSM live in one file: one always_ff and one always_comb for next-state and outputs.

## Test plan
- Good packet: d_edge; SYNC 0x80; data 0xA5, 0x3C; aligned EOP. Response: two w_enable pulses with rcv_data 0xA5 then 0x3C, pkt_done once, r_error=0.
- Bad SYNC (byte 0x81): r_error=1 after CHK_SYNC, no w_enable. ERR_IDLE after EOP; next d_edge clears r_error.
- Stuffing: data 0xFF after SYNC. A 0 is inserted after the 6th one (5 data ones plus SYNC's trailing 1) and is not shifted. w_enable shows 0xFF after 9 valid samples.
- Stuff error: seven consecutive 1s → r_error=1, w_enable never asserted for that byte.
- EOP at bit_cnt==3 in DATA → r_error=1, no pkt_done.
- MAX_BYTES=2: 3 data bytes give exactly 2 w_enable pulses, then r_error=1. Separately, n_rst low mid-byte gives all outputs 0 on the next edge.

Source files
------------

// File: rtl/usb_rx_pkg.sv
// usb_rx_pkg: shared types and constants for the USB full-speed receive controller.
//   rx_state_t     receive FSM state encoding
//   STUFF_LIMIT    run of ones after which the next bit is a stuffed zero
//   BITS_PER_BYTE  bits assembled per received byte
package usb_rx_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StSync,
        StChkSync,
        StData,
        StStore,
        StEopWait,
        StErrEop,
        StErrIdle
    } rx_state_t;

    localparam int unsigned STUFF_LIMIT   = 6;
    localparam int unsigned BITS_PER_BYTE = 8;

endpackage

// File: rtl/usb_rx_ctrl.sv
// usb_rx_ctrl: receive control for one USB full-speed packet at a time. Detects packet start,
// validates SYNC, drops stuffed bits, counts bits into bytes, strobes FIFO writes and checks
// that EOP lands on a byte boundary.
// Ports:
//   clk, n_rst    clock, asynchronous active-low reset
//   d_edge        pulse: transition on d_plus (packet start in idle states)
//   eop           level: SE0 on the bus
//   shift_enable  pulse: bit-sample strobe
//   d_orig        decoded bit, valid with shift_enable
//   rcv_data      shift-register contents
//   shift_gate    combinational: shift the register this cycle
//   rcving        reception in progress
//   w_enable      one-cycle FIFO write strobe
//   r_error       packet error, held until the next packet start
//   pkt_done      one-cycle pulse on a clean packet end
module usb_rx_ctrl
    import usb_rx_pkg::*;
#(
    parameter logic [7:0]  SYNC_BYTE = 8'h80,
    parameter int unsigned MAX_BYTES = 64
) (
    input  logic       clk,
    input  logic       n_rst,
    input  logic       d_edge,
    input  logic       eop,
    input  logic       shift_enable,
    input  logic       d_orig,
    input  logic [7:0] rcv_data,
    output logic       shift_gate,
    output logic       rcving,
    output logic       w_enable,
    output logic       r_error,
    output logic       pkt_done
);

    localparam int unsigned    BcW      = $clog2(MAX_BYTES + 1);
    localparam logic [BcW-1:0] MaxCnt   = BcW'(MAX_BYTES);
    localparam logic [3:0]     BitsFull = 4'(BITS_PER_BYTE);
    localparam logic [2:0]     OnesFull = 3'(STUFF_LIMIT);

    rx_state_t      state_q, state_d;
    logic [3:0]     bit_cnt_q, bit_cnt_d;
    logic [2:0]     ones_cnt_q, ones_cnt_d;
    logic [BcW-1:0] byte_cnt_q, byte_cnt_d;
    logic           eop_seen_q, eop_seen_d;
    logic           pkt_done_q, pkt_done_d;
    logic           valid;
    logic           stuff_err;

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q    <= StIdle;
            bit_cnt_q  <= '0;
            ones_cnt_q <= '0;
            byte_cnt_q <= '0;
            eop_seen_q <= 1'b0;
            pkt_done_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            bit_cnt_q  <= bit_cnt_d;
            ones_cnt_q <= ones_cnt_d;
            byte_cnt_q <= byte_cnt_d;
            eop_seen_q <= eop_seen_d;
            pkt_done_q <= pkt_done_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        bit_cnt_d  = bit_cnt_q;
        ones_cnt_d = ones_cnt_q;
        byte_cnt_d = byte_cnt_q;
        eop_seen_d = eop_seen_q;
        pkt_done_d = 1'b0;
        shift_gate = 1'b0;
        stuff_err  = 1'b0;

        // A sample coinciding with SE0 is never shifted; EOP rules take over.
        valid = shift_enable && !eop && (state_q == StSync || state_q == StData);

        if (valid) begin
            if (ones_cnt_q == OnesFull) begin
                // Stuffed position: a zero is discarded, a one is a protocol violation.
                if (d_orig) begin
                    stuff_err = 1'b1;
                end else begin
                    ones_cnt_d = '0;
                end
            end else begin
                shift_gate = 1'b1;
                bit_cnt_d  = bit_cnt_q + 4'd1;
                ones_cnt_d = d_orig ? ones_cnt_q + 3'd1 : 3'd0;
            end
        end

        case (state_q)
            StIdle, StErrIdle: begin
                if (d_edge) begin
                    state_d    = StSync;
                    bit_cnt_d  = '0;
                    ones_cnt_d = '0;
                    byte_cnt_d = '0;
                end
            end
            StSync: begin
                if (eop && shift_enable) begin
                    state_d = StErrEop;
                end else if (stuff_err) begin
                    state_d = StErrEop;
                end else if (bit_cnt_d == BitsFull) begin
                    state_d = StChkSync;
                end
            end
            StChkSync: begin
                // ones_cnt is kept: SYNC's trailing one counts toward the stuffing run.
                if (rcv_data == SYNC_BYTE) begin
                    state_d   = StData;
                    bit_cnt_d = '0;
                end else begin
                    state_d = StErrEop;
                end
            end
            StData: begin
                if (eop && shift_enable) begin
                    state_d = (bit_cnt_q == 4'd0) ? StEopWait : StErrEop;
                end else if (stuff_err) begin
                    state_d = StErrEop;
                end else if (bit_cnt_d == BitsFull) begin
                    state_d = StStore;
                end
            end
            StStore: begin
                if (byte_cnt_q == MaxCnt) begin
                    state_d = StErrEop;
                end else begin
                    state_d    = StData;
                    byte_cnt_d = byte_cnt_q + BcW'(1);
                    bit_cnt_d  = '0;
                end
            end
            StEopWait: begin
                if (!eop) begin
                    state_d    = StIdle;
                    pkt_done_d = 1'b1;
                end
            end
            StErrEop: begin
                // Leave only after a full SE0 has been seen and released.
                if (eop) begin
                    eop_seen_d = 1'b1;
                end else if (eop_seen_q) begin
                    eop_seen_d = 1'b0;
                    state_d    = StErrIdle;
                end
            end
            default: state_d = StIdle;
        endcase

        rcving   = (state_q == StSync) || (state_q == StChkSync) || (state_q == StData) ||
                   (state_q == StStore) || (state_q == StEopWait);
        w_enable = (state_q == StStore) && (byte_cnt_q != MaxCnt);
        r_error  = (state_q == StErrEop) || (state_q == StErrIdle);
        pkt_done = pkt_done_q;
    end

endmodule

// File: tb/tb_usb_rx_ctrl.sv
// tb_usb_rx_ctrl: directed bench for usb_rx_ctrl (MAX_BYTES=2). Models the external shift
// register, records FIFO writes and packet-done pulses, and checks each scenario.
module tb_usb_rx_ctrl;

    logic       clk = 1'b0;
    logic       n_rst = 1'b0;
    logic       d_edge = 1'b0;
    logic       eop = 1'b0;
    logic       shift_enable = 1'b0;
    logic       d_orig = 1'b0;
    logic [7:0] sr = 8'h00;
    logic       shift_gate, rcving, w_enable, r_error, pkt_done;

    int         n_vec = 0;
    int         n_bad = 0;
    int         pkt_cnt = 0;
    logic [7:0] wq[$];
    logic       last_sg;
    int         wb, pb;

    usb_rx_ctrl #(
        .SYNC_BYTE(8'h80),
        .MAX_BYTES(2)
    ) dut (
        .clk         (clk),
        .n_rst       (n_rst),
        .d_edge      (d_edge),
        .eop         (eop),
        .shift_enable(shift_enable),
        .d_orig      (d_orig),
        .rcv_data    (sr),
        .shift_gate  (shift_gate),
        .rcving      (rcving),
        .w_enable    (w_enable),
        .r_error     (r_error),
        .pkt_done    (pkt_done)
    );

    always #5 clk = ~clk;

    // LSB-first shift register: first received bit ends up in bit 0.
    always @(posedge clk) begin
        if (shift_gate) sr <= {d_orig, sr[7:1]};
    end

    always @(negedge clk) begin
        if (n_rst) begin
            if (w_enable) wq.push_back(sr);
            if (pkt_done) pkt_cnt <= pkt_cnt + 1;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp)
        else begin
            n_bad++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        n_rst = 1'b0;
        #3;
        n_rst = 1'b1;
        tick();
    endtask

    task automatic start_pkt();
        d_edge = 1'b1;
        tick();
        d_edge = 1'b0;
        tick();
    endtask

    task automatic send_bit(input logic b);
        d_orig       = b;
        shift_enable = 1'b1;
        #1;
        last_sg = shift_gate;
        tick();
        shift_enable = 1'b0;
        repeat (3) tick();
    endtask

    task automatic send_byte(input logic [7:0] b);
        for (int i = 0; i < 8; i++) send_bit(b[i]);
    endtask

    task automatic send_eop();
        eop          = 1'b1;
        shift_enable = 1'b1;
        tick();
        shift_enable = 1'b0;
        repeat (2) tick();
        eop = 1'b0;
        repeat (2) tick();
    endtask

    initial begin
        // Reset state
        #2;
        chk("rst_rcving", rcving, 0);
        chk("rst_wen", w_enable, 0);
        chk("rst_rerr", r_error, 0);
        chk("rst_done", pkt_done, 0);
        chk("rst_sgate", shift_gate, 0);
        do_reset();

        // Good packet: SYNC, 0xA5, 0x3C, aligned EOP; a stray d_edge mid-packet is ignored
        wb = wq.size();
        pb = pkt_cnt;
        start_pkt();
        chk("good_rcving_sync", rcving, 1);
        send_byte(8'h80);
        chk("good_sync_sgate", last_sg, 1);
        send_byte(8'hA5);
        d_edge = 1'b1;
        tick();
        d_edge = 1'b0;
        tick();
        chk("good_dedge_ignored", rcving, 1);
        send_byte(8'h3C);
        send_eop();
        chk("good_wcount", wq.size() - wb, 2);
        chk("good_byte0", wq[wb], 8'hA5);
        chk("good_byte1", wq[wb+1], 8'h3C);
        chk("good_done", pkt_cnt - pb, 1);
        chk("good_rerr", r_error, 0);
        chk("good_idle", rcving, 0);

        // Bad SYNC 0x81
        do_reset();
        wb = wq.size();
        start_pkt();
        send_byte(8'h81);
        chk("bsync_rerr", r_error, 1);
        chk("bsync_rcving", rcving, 0);
        send_eop();
        chk("bsync_erridle_rerr", r_error, 1);
        chk("bsync_wcount", wq.size() - wb, 0);
        start_pkt();
        chk("bsync_clear_rerr", r_error, 0);
        chk("bsync_restart", rcving, 1);

        // Stuffing: 0xFF after SYNC, stuffed zero after the sixth one
        do_reset();
        wb = wq.size();
        pb = pkt_cnt;
        start_pkt();
        send_byte(8'h80);
        for (int i = 0; i < 5; i++) send_bit(1'b1);
        chk("stuff_pre_sgate", last_sg, 1);
        send_bit(1'b0);
        chk("stuff_drop_sgate", last_sg, 0);
        chk("stuff_mid_wcount", wq.size() - wb, 0);
        for (int i = 0; i < 3; i++) send_bit(1'b1);
        chk("stuff_wcount", wq.size() - wb, 1);
        chk("stuff_byte", wq[wb], 8'hFF);
        send_eop();
        chk("stuff_done", pkt_cnt - pb, 1);
        chk("stuff_rerr", r_error, 0);

        // Stuff error: SYNC's trailing one plus six data ones
        do_reset();
        wb = wq.size();
        start_pkt();
        send_byte(8'h80);
        for (int i = 0; i < 6; i++) send_bit(1'b1);
        chk("serr_sgate", last_sg, 0);
        chk("serr_rerr", r_error, 1);
        d_edge = 1'b1;
        tick();
        d_edge = 1'b0;
        tick();
        chk("serr_dedge_ignored", r_error, 1);
        send_bit(1'b0);
        send_bit(1'b1);
        send_eop();
        chk("serr_erridle", r_error, 1);
        chk("serr_rcving", rcving, 0);
        chk("serr_wcount", wq.size() - wb, 0);

        // EOP at bit_cnt==3 in DATA
        do_reset();
        pb = pkt_cnt;
        start_pkt();
        send_byte(8'h80);
        send_bit(1'b0);
        send_bit(1'b1);
        send_bit(1'b0);
        send_eop();
        chk("meop_rerr", r_error, 1);
        chk("meop_done", pkt_cnt - pb, 0);

        // Overflow with MAX_BYTES=2
        do_reset();
        wb = wq.size();
        start_pkt();
        send_byte(8'h80);
        send_byte(8'h11);
        send_byte(8'h22);
        chk("ovf_rerr_before", r_error, 0);
        send_byte(8'h33);
        chk("ovf_wcount", wq.size() - wb, 2);
        chk("ovf_byte0", wq[wb], 8'h11);
        chk("ovf_byte1", wq[wb+1], 8'h22);
        chk("ovf_rerr", r_error, 1);
        chk("ovf_rcving", rcving, 0);

        // Reset mid-byte
        do_reset();
        wb = wq.size();
        start_pkt();
        send_byte(8'h80);
        send_bit(1'b1);
        send_bit(1'b0);
        send_bit(1'b1);
        chk("mrst_rcving_before", rcving, 1);
        n_rst = 1'b0;
        #2;
        chk("mrst_rcving", rcving, 0);
        chk("mrst_rerr", r_error, 0);
        tick();
        chk("mrst_edge_rcving", rcving, 0);
        chk("mrst_edge_wen", w_enable, 0);
        chk("mrst_edge_done", pkt_done, 0);
        chk("mrst_edge_rerr", r_error, 0);
        n_rst = 1'b1;
        repeat (8) tick();
        chk("mrst_no_write", wq.size() - wb, 0);
        chk("mrst_stays_idle", rcving, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
